// File: rtl/mont_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mont_operand_feeder
// Purpose  : Operand feeder for the pipelined Montgomery reducer. Accepts
//            (a, b) coefficient pairs over valid/ready. It multiplies them in
//            a two-stage pipeline (S1 capture, S2 full-width product). The
//            products are buffered in a small FIFO and presented as the
//            reducer's x/start stream. Input credits count pipeline stages
//            plus FIFO entries, so the FIFO can never be written while full.
//
// Ports    : clk_i        rising-edge clock
//            rst_i        asynchronous active-high reset
//            flush_i      synchronous clear of pipeline and FIFO
//            in_valid_i   operand pair valid
//            in_ready_o   feeder can accept a pair (registered state only)
//            a_i, b_i     operands (OP_W bits)
//            m_i          modulus, used only by the optional range check
//            out_valid_o  product valid (FIFO not empty) -> reducer start_i
//            out_ready_i  downstream accepts the product
//            out_x_o      zero-extended product (FIFO head) -> reducer x_i
//            count_o      entries in flight plus entries buffered
//            err_o        sticky range-check error
//
// Config   : MONT_FEEDER_RANGE_CHECK_EN
//              defined   - err_o is set when an accepted operand is >= m_i
//              undefined - err_o is tied low and m_i is ignored
//
// Revision : 1.0  initial release
// ============================================================================
module mont_operand_feeder #(
    parameter int OP_W       = 32,
    parameter int DATA_W     = 64,   // must be >= 2*OP_W
    parameter int FIFO_DEPTH = 4     // power of two, >= 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [OP_W-1:0]                   a_i,
    input  logic [OP_W-1:0]                   b_i,
    input  logic [OP_W-1:0]                   m_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [DATA_W-1:0]                 out_x_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              err_o
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_PROD_W = 2 * OP_W;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                  r_s1_valid;
    logic [OP_W-1:0]       r_s1_a;
    logic [OP_W-1:0]       r_s1_b;
    logic                  r_s2_valid;
    logic [DATA_W-1:0]     r_s2_x;

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_fifo_cnt;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [c_CNT_W-1:0]    w_used;
    logic [c_PROD_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_prod_ext;

    // Every stage that holds a pair owns one FIFO credit. Because the sum is
    // built from registers only, a pop in this cycle cannot raise ready, and
    // there is no combinational path from out_ready_i to in_ready_o.
    assign w_used = r_fifo_cnt + c_CNT_W'(r_s1_valid) + c_CNT_W'(r_s2_valid);

    assign in_ready_o  = !rst_i && (w_used < c_DEPTH);
    assign count_o     = w_used;
    assign out_valid_o = (r_fifo_cnt != '0);
    assign out_x_o     = r_mem[r_rd_ptr];

    // A pair presented together with flush is dropped, as is any pop or push.
    assign w_accept = in_valid_i && in_ready_o && !flush_i;
    assign w_push   = r_s2_valid && !flush_i;
    assign w_pop    = out_valid_o && out_ready_i && !flush_i;

    // Unsigned full-width product, then zero-extended to the output width.
    assign w_prod     = {{OP_W{1'b0}}, r_s1_a} * {{OP_W{1'b0}}, r_s1_b};
    assign w_prod_ext = DATA_W'(w_prod);

    // ------------------------------------------------------------------------
    // S1: operand capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a <= a_i;
                r_s1_b <= b_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // S2: product register. The pipeline never stalls; the credit check at
    // the input guarantees S2 always finds a free FIFO slot.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_x     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && !flush_i;
            if (r_s1_valid) begin
                r_s2_x <= w_prod_ext;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO storage. The head is read straight from the storage array,
    // so out_x_o is always a registered value and never bypasses the write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= r_s2_x;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; full and empty come
    // from the separate occupancy counter rather than pointer comparison.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            // Simultaneous push and pop leaves the occupancy unchanged,
            // whether the FIFO is full or empty at the time.
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional operand range check
    // ------------------------------------------------------------------------
`ifdef MONT_FEEDER_RANGE_CHECK_EN
    logic r_err;

    // Sticky until reset: flush deliberately leaves it alone so a bad
    // operand is never hidden by a subsequent pipeline clear. The product of
    // an out-of-range pair is still computed and forwarded unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_accept && ((a_i >= m_i) || (b_i >= m_i))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_m;

    assign w_unused_m = ^m_i;
    assign err_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mont_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mont_operand_feeder
// Purpose  : Self-checking bench for mont_operand_feeder. A queue-based
//            model (pairs in flight with their age, plus a product FIFO)
//            predicts the outputs every cycle. Directed scenarios pin the
//            model with hand-computed products, latency and back-pressure.
// Revision : 1.0  initial release
// ============================================================================
module tb_mont_operand_feeder;

    localparam int OP_W       = 32;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

`ifdef MONT_FEEDER_RANGE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [OP_W-1:0]   a_i;
    logic [OP_W-1:0]   b_i;
    logic [OP_W-1:0]   m_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_x_o;
    logic [CNT_W-1:0]  count_o;
    logic              err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mont_operand_feeder #(
        .OP_W       (OP_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .m_i         (m_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_x_o     (out_x_o),
        .count_o     (count_o),
        .err_o       (err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: an accepted pair lands in the product FIFO two edges
    // after acceptance; credits are (pairs in flight + FIFO entries).
    // ------------------------------------------------------------------------
    logic [63:0] pipe_v [$];
    int          pipe_age [$];
    logic [63:0] fifo_q [$];
    logic        m_err = 1'b0;

    always @(posedge clk_i) begin : model
        int          used;
        logic        acc;
        logic [63:0] p;
        if (rst_i) begin
            pipe_v.delete();
            pipe_age.delete();
            fifo_q.delete();
            m_err = 1'b0;
        end else begin
            used = fifo_q.size() + pipe_v.size();
            acc  = in_valid_i && (used < FIFO_DEPTH);
            if (flush_i) begin
                pipe_v.delete();
                pipe_age.delete();
                fifo_q.delete();
            end else begin
                if (out_ready_i && fifo_q.size() > 0) void'(fifo_q.pop_front());
                foreach (pipe_age[i]) pipe_age[i] = pipe_age[i] + 1;
                while (pipe_age.size() > 0 && pipe_age[0] >= 2) begin
                    fifo_q.push_back(pipe_v[0]);
                    void'(pipe_v.pop_front());
                    void'(pipe_age.pop_front());
                end
                if (acc) begin
                    p = {32'b0, a_i} * {32'b0, b_i};
                    pipe_v.push_back(p);
                    pipe_age.push_back(0);
`ifdef MONT_FEEDER_RANGE_CHECK_EN
                    if (a_i >= m_i || b_i >= m_i) m_err = 1'b1;
`endif
                end
            end
            #1;
            used = fifo_q.size() + pipe_v.size();
            check("m_out_valid", 64'(out_valid_o), 64'(fifo_q.size() > 0));
            if (fifo_q.size() > 0) check("m_out_x", out_x_o, fifo_q[0]);
            check("m_count", 64'(count_o), 64'(used));
            check("m_in_ready", 64'(in_ready_o), 64'(used < FIFO_DEPTH));
            check("m_err", 64'(err_o), 64'(m_err));
        end
    end

    // One pair with out_ready_i=1: valid on the 3rd negedge after the accept
    // edge, then exactly one pop.
    task automatic single(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
        int k;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        a_i = a;
        b_i = b;
        check({nm, "_ready"}, 64'(in_ready_o), 64'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        k = 1;
        while (!out_valid_o && k < 10) begin
            @(negedge clk_i);
            k++;
        end
        check({nm, "_latency"}, 64'(k), 64'd3);
        check({nm, "_x"}, out_x_o, exp);
        @(negedge clk_i);
        check({nm, "_one_pop"}, 64'(out_valid_o), 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] pa [5];
        logic [63:0] got [5];
        int          idx;
        int          nout;
        logic        acc;
        logic        popping;

        pa[0] = 1; pa[1] = 2; pa[2] = 3; pa[3] = 4; pa[4] = 5;
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
        a_i = '0; b_i = '0; m_i = 32'h007F_E001; out_ready_i = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_out_x", out_x_o, 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk_i);

        // Single pair and maximum Dilithium operands
        single(32'h1234, 32'h5678, 64'h0626_0060, "single");
        single(32'h007F_E000, 32'h007F_E000, 64'h3FE0_0400_0000, "max");

        // Back-pressure: four credits, fifth pair held off
        out_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid_i = 1'b1;
            a_i = pa[idx];
            b_i = pa[idx];
            acc = in_ready_o;
            @(negedge clk_i);
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd4);
        check("bp_in_ready", 64'(in_ready_o), 64'd0);
        check("bp_count", 64'(count_o), 64'd4);

        out_ready_i = 1'b1;
        nout = 0;
        for (int c = 0; c < 20 && nout < 5; c++) begin
            if (idx < 5) begin
                in_valid_i = 1'b1;
                a_i = pa[idx];
                b_i = pa[idx];
            end else begin
                in_valid_i = 1'b0;
            end
            acc     = in_valid_i && in_ready_o;
            popping = out_valid_o && out_ready_i;
            if (popping) got[nout] = out_x_o;
            @(negedge clk_i);
            if (acc) idx++;
            if (popping) nout++;
            if (c == 0) check("bp_ready_after_pop", 64'(in_ready_o), 64'd1);
        end
        in_valid_i = 1'b0;
        check("bp_nout", 64'(nout), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_out%0d", i), got[i], 64'((i + 1) * (i + 1)));
        end

        // Flush mid-stream with a 4th pair presented on the flush edge
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            a_i = 32'(10 + i);
            b_i = 32'(10 + i);
            @(negedge clk_i);
        end
        a_i = 32'd20;
        b_i = 32'd20;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_out_valid", 64'(out_valid_o), 64'd0);
        repeat (4) begin
            @(negedge clk_i);
            check("flush_no_valid", 64'(out_valid_o), 64'd0);
        end
        single(32'd7, 32'd6, 64'h2A, "post_flush");

        // Range check: out-of-range operand still produces its product
        single(32'h007F_E001, 32'd2, 64'h00FF_C002, "range");
        check("range_err", 64'(err_o), 64'(EXP_ERR));
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("range_err_after_flush", 64'(err_o), 64'(EXP_ERR));

        // Asynchronous reset with two buffered products
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        a_i = 32'd3; b_i = 32'd3;
        @(negedge clk_i);
        a_i = 32'd4; b_i = 32'd4;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("ar_pre_count", 64'(count_o), 64'd2);
        check("ar_pre_valid", 64'(out_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid_o), 64'd0);
        check("ar_count", 64'(count_o), 64'd0);
        check("ar_in_ready", 64'(in_ready_o), 64'd0);
        check("ar_err", 64'(err_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("ar_release_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk_i);
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mont_operand_feeder.md
# mont_operand_feeder

Upstream stage of `montgomery_pipelined`. Accepts coefficient operand pairs over a valid/ready handshake and multiplies them in a two-stage pipeline. Buffers the 64-bit products in a small output FIFO and presents them as the `x_i`/`start_i` stream the Montgomery reducer consumes. A downstream ready input stalls the stream, for example while the reducer's modulus constants are being reloaded, and a credit scheme keeps the FIFO from overflowing.

## Interface
- `OP_W`, default 32: operand width (coefficients in Montgomery domain, < `m_i`).
- `DATA_W`, default 64: product width; must be ≥ 2·`OP_W`.
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, ≥ 4.
- `clk_i` in, 1: rising-edge clock.
- `rst_i` in, 1: asynchronous active-high reset.
- `flush_i` in, 1: synchronous clear of pipeline and FIFO.
- `in_valid_i` in, 1: operand pair valid.
- `in_ready_o` out, 1: feeder can accept a pair.
- `a_i` in, `OP_W`: operand a.
- `b_i` in, `OP_W`: operand b.
- `m_i` in, `OP_W`: modulus (e.g. 0x7FE001); used only by the range check.
- `out_valid_o` out, 1: product valid; drives reducer `start_i`.
- `out_ready_i` in, 1: downstream accepts the product.
- `out_x_o` out, `DATA_W`: product a·b, zero-extended; drives reducer `x_i`.
- `count_o` out, $clog2(`FIFO_DEPTH`+1): entries in flight plus entries buffered.
- `err_o` out, 1: sticky range-check error.

## Operation
- Accept occurs when `in_valid_i && in_ready_o` at a rising edge: a and b are captured into S1.
- Next edge: S2 ← a·b, an unsigned full-width product with no truncation.
- Next edge: S2 is written to the FIFO tail.
- Pop occurs when `out_valid_o && out_ready_i`. `out_valid_o` = FIFO not empty; `out_x_o` = FIFO head (head register, not combinational from the write).
- `used` = FIFO count + S1 valid + S2 valid. `count_o` = `used`.
- `in_ready_o` = !`rst_i` && `used` < `FIFO_DEPTH`. It is computed from registered state only: a pop in the same cycle does not raise ready, and there is no path from `out_ready_i` to `in_ready_o`.
- The pipeline never stalls internally. Credits guarantee a FIFO slot for every accepted pair, so a FIFO write when full is unreachable.
- Simultaneous push and pop with the FIFO full or empty are both legal; the count is unchanged.
- `flush_i`: at the edge, S1/S2 valid ← 0, FIFO pointers ← 0, count ← 0. An accept in the same cycle is discarded. `err_o` is not cleared by flush.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally; full/empty are derived from the separate count register.
- Order is strictly FIFO; products leave in acceptance order.

## Timing
- Reset values:
  - `out_valid_o` = 0, `count_o` = 0, `err_o` = 0, `out_x_o` = 0.
  - `in_ready_o` = 0 while `rst_i` is high, and 1 in the first cycle after deassertion.
- Latency: a pair accepted at edge E0 is written to the FIFO at edge E2. `out_valid_o` rises after E2 when the FIFO was empty (3-cycle accept-to-valid).
- Throughput is one pair per cycle with `out_ready_i` held at 1; steady-state `used` ≤ 3.
- If `rst_i` is asserted mid-stream, all state clears immediately (asynchronously); in-flight products are lost.

## Configuration
- `MONT_FEEDER_RANGE_CHECK_EN`
- Defined: at accept, if a ≥ `m_i` or b ≥ `m_i`, `err_o` is set at that edge and stays high until reset. The product is still computed and forwarded unchanged.
- Undefined: `err_o` is tied to 0 and `m_i` is unused.

## Test plan
- Single pair: reset, a=0x1234, b=0x5678, `out_ready_i`=1 → `out_valid_o` high 3 cycles after accept with `out_x_o`=0x6260060, and exactly one pop.
- Max Dilithium operands: a=b=0x7FE000 → `out_x_o`=0x3FE004000000.
- Back-pressure:
  - Hold `out_ready_i`=0 and drive `in_valid_i`=1 with pairs (1,1),(2,2),(3,3),(4,4),(5,5): 4 accepted, then `in_ready_o`=0 with `count_o`=4.
  - Release `out_ready_i`: outputs 1,4,9,16,25 in order, and `in_ready_o` reasserts the cycle after the first pop.
- Flush mid-stream: 3 pairs accepted, `flush_i` pulsed together with a 4th valid pair → `count_o`=0 next cycle, no `out_valid_o` pulse, next pair (7,6) yields 0x2A.
- Range check, with the macro defined and `m_i`=0x7FE001:
  - a=0x7FE001, b=2 → `err_o`=1 after the accept edge and stays high after flush; product 0xFFC002 is still output.
  - With the macro undefined → `err_o` stays 0.
- Async reset: assert `rst_i` between edges with the FIFO holding 2 entries → `out_valid_o` and `count_o` go to 0 immediately, with no clock edge needed.
